// File: rtl/fifo_arb_pkg.sv
// rtl/fifo_arb_pkg.sv - shared state encoding, default sizes and index-width helper for fifo_rr_arbiter
package fifo_arb_pkg;

    // 2'b11 is unused and decodes back to IDLE in the top-level FSM.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_ACTIVE = 2'b01,
        ST_STALL  = 2'b10
    } state_e;

    localparam int N_IN_DEF  = 4;
    localparam int W_DEF     = 6;
    localparam int CNT_W_DEF = 16;

    // Index width for N_IN inputs; never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fifo_rr_arbiter_rr_pick.sv
// rtl/fifo_rr_arbiter_rr_pick.sv - combinational round-robin winner selection
//
// Ports:
//   req_i   [N_IN]   request (non-empty) per input
//   ptr_i   [IDX_W]  index with highest priority this cycle
//   valid_o          at least one request present
//   idx_o   [IDX_W]  winning index
// With ARB_STRICT_PRIO_EN defined the pointer is ignored and the lowest
// requesting index wins.
module rr_pick #(
    parameter int N_IN  = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_IN-1:0]  req_i,
    input  logic [IDX_W-1:0] ptr_i,
    output logic             valid_o,
    output logic [IDX_W-1:0] idx_o
);

    logic [IDX_W-1:0]  eff_ptr;
    logic [N_IN-1:0]   mask;
    logic [2*N_IN-1:0] dbl;
    logic              found;

    always_comb begin
`ifdef ARB_STRICT_PRIO_EN
        eff_ptr = '0;
`else
        eff_ptr = ptr_i;
`endif
        for (int i = 0; i < N_IN; i++) begin
            mask[i] = (i >= int'(eff_ptr));
        end
        // Lower copy holds only requests at/after the pointer, upper copy
        // holds all of them, so a plain LSB-first scan wraps naturally.
        dbl   = {req_i, req_i & mask};
        found = 1'b0;
        idx_o = '0;
        for (int i = 0; i < 2*N_IN; i++) begin
            if (!found && dbl[i]) begin
                found = 1'b1;
                idx_o = (i >= N_IN) ? IDX_W'(i - N_IN) : IDX_W'(i);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/fifo_rr_arbiter.sv
// rtl/fifo_rr_arbiter.sv - round-robin arbiter draining N_IN FWFT input FIFOs into one output FIFO
//
// Ports:
//   clk_i              clock, rising edge
//   rst_ni             asynchronous active-low reset
//   init_i             synchronous clear of pointer/counter, forces IDLE
//   enable_i           arbitration allowed
//   fifo_empty_i [N]   per-input empty flag
//   fifo_data_i  [N*W] head words, input i at [i*W +: W]
//   out_almost_full_i  output FIFO at/above high threshold
//   pop_o        [N]   one-hot pop (combinational)
//   push_o             registered write strobe to output FIFO
//   data_out_o   [W]   registered output word, holds when push_o=0
//   grant_idx_o        last granted input
//   busy_o             state != IDLE
//   words_sent_o       saturating push count
// Build option: ARB_STRICT_PRIO_EN selects fixed lowest-index priority.
module fifo_rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int N_IN  = N_IN_DEF,
    parameter int W     = W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int IDX_W = idx_w(N_IN)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              init_i,
    input  logic              enable_i,
    input  logic [N_IN-1:0]   fifo_empty_i,
    input  logic [N_IN*W-1:0] fifo_data_i,
    input  logic              out_almost_full_i,
    output logic [N_IN-1:0]   pop_o,
    output logic              push_o,
    output logic [W-1:0]      data_out_o,
    output logic [IDX_W-1:0]  grant_idx_o,
    output logic              busy_o,
    output logic [CNT_W-1:0]  words_sent_o
);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]   grant_q, grant_d;
    logic               push_q, push_d;
    logic [W-1:0]       data_q, data_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [N_IN-1:0]    req;
    logic               win_valid;
    logic [IDX_W-1:0]   win_idx;
    logic               any_req;
    logic               pop_en;

    assign req     = ~fifo_empty_i;
    assign any_req = |req;

    rr_pick #(
        .N_IN  (N_IN),
        .IDX_W (IDX_W)
    ) u_pick (
        .req_i   (req),
        .ptr_i   (rr_ptr_q),
        .valid_o (win_valid),
        .idx_o   (win_idx)
    );

    // Popping is allowed in IDLE too, so the first word leaves the same
    // cycle the FSM decides to go ACTIVE. rst_ni gates it so pop drops
    // immediately when reset asserts.
    assign pop_en = rst_ni && enable_i && !init_i && !out_almost_full_i &&
                    (state_q != ST_STALL) && win_valid;

    always_comb begin
        pop_o = '0;
        if (pop_en) begin
            pop_o[win_idx] = 1'b1;
        end
    end

    always_comb begin
        state_d = state_q;
        if (init_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (enable_i && any_req) begin
                        state_d = out_almost_full_i ? ST_STALL : ST_ACTIVE;
                    end
                end
                ST_ACTIVE: begin
                    if (!enable_i || !any_req) begin
                        state_d = ST_IDLE;
                    end else if (out_almost_full_i) begin
                        state_d = ST_STALL;
                    end
                end
                ST_STALL: begin
                    if (!enable_i || !any_req) begin
                        state_d = ST_IDLE;
                    end else if (!out_almost_full_i) begin
                        state_d = ST_ACTIVE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        grant_d  = grant_q;
        data_d   = data_q;
        push_d   = pop_en;
        if (pop_en) begin
            grant_d = win_idx;
            data_d  = fifo_data_i[int'(win_idx)*W +: W];
`ifdef ARB_STRICT_PRIO_EN
            rr_ptr_d = '0;
`else
            rr_ptr_d = (win_idx == IDX_W'(N_IN - 1)) ? '0 : win_idx + 1'b1;
`endif
        end
        if (init_i) begin
            rr_ptr_d = '0;
        end
        // The push of a word popped last cycle still lands during init;
        // only the count is cleared.
        cnt_d = cnt_q;
        if (init_i) begin
            cnt_d = '0;
        end else if (push_q && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            rr_ptr_q <= '0;
            grant_q  <= '0;
            push_q   <= 1'b0;
            data_q   <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            rr_ptr_q <= rr_ptr_d;
            grant_q  <= grant_d;
            push_q   <= push_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
        end
    end

    assign push_o       = push_q;
    assign data_out_o   = data_q;
    assign grant_idx_o  = grant_q;
    assign busy_o       = (state_q != ST_IDLE);
    assign words_sent_o = cnt_q;

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
// tb/tb_fifo_rr_arbiter.sv - scoreboard bench for fifo_rr_arbiter with queue-based FIFO reference model
module tb_fifo_rr_arbiter;

    localparam int N = 4;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic init = 1'b0;
    logic enable = 1'b0;
    logic afull = 1'b0;
    logic [N-1:0]   fempty;
    logic [N*W-1:0] fdata;

    logic [N-1:0] pop_a, pop_b;
    logic         push_a, push_b;
    logic [W-1:0] dout_a, dout_b;
    logic [1:0]   gidx_a, gidx_b;
    logic         busy_a, busy_b;
    logic [15:0]  ws_a;
    logic [3:0]   ws_b;

    always #5 clk = ~clk;

    fifo_rr_arbiter #(.N_IN(N), .W(W), .CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .enable_i(enable),
        .fifo_empty_i(fempty), .fifo_data_i(fdata), .out_almost_full_i(afull),
        .pop_o(pop_a), .push_o(push_a), .data_out_o(dout_a), .grant_idx_o(gidx_a),
        .busy_o(busy_a), .words_sent_o(ws_a)
    );

    fifo_rr_arbiter #(.N_IN(N), .W(W), .CNT_W(4)) dut_sat (
        .clk_i(clk), .rst_ni(rst_n), .init_i(init), .enable_i(enable),
        .fifo_empty_i(fempty), .fifo_data_i(fdata), .out_almost_full_i(afull),
        .pop_o(pop_b), .push_o(push_b), .data_out_o(dout_b), .grant_idx_o(gidx_b),
        .busy_o(busy_b), .words_sent_o(ws_b)
    );

    // Reference model
    logic [W-1:0] q [N][$];
    logic [W-1:0] sb [$];
    int           m_rr = 0;
    int           m_grant = 0;
    bit           m_stall = 0;
    bit           m_busy = 0;
    bit           m_push = 0;
    int           m_cnt = 0;
    int           m_cnt4 = 0;
    logic [W-1:0] m_last = '0;
    int           n_tests = 0;
    int           n_fail = 0;
    int           mw;
    bit           mok;

    function automatic int winner();
        int base;
`ifdef ARB_STRICT_PRIO_EN
        base = 0;
`else
        base = m_rr;
`endif
        for (int k = 0; k < N; k++) begin
            if (q[(base + k) % N].size() > 0) return (base + k) % N;
        end
        return -1;
    endfunction

    function automatic bit pop_ok();
        return enable && !init && !afull && !m_stall && (winner() >= 0);
    endfunction

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            fempty[i] = (q[i].size() == 0);
            fdata[i*W +: W] = (q[i].size() > 0) ? q[i][0] : '0;
        end
    endtask

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst_n) begin
            mw  = winner();
            mok = pop_ok();
            if (init) begin
                m_cnt  = 0;
                m_cnt4 = 0;
            end else if (m_push) begin
                if (m_cnt != 65535) m_cnt++;
                if (m_cnt4 != 15) m_cnt4++;
            end
            if (mok) begin
                sb.push_back(q[mw].pop_front());
                m_grant = mw;
                m_rr = (mw + 1) % N;
            end
            if (init) m_rr = 0;
            m_stall = !init && enable && (mw >= 0) && afull;
            m_busy  = !init && enable && (mw >= 0);
            m_push  = mok;
            #1 refresh();
        end
    end

    // An async reset throws away any word in flight.
    always @(negedge rst_n) begin
        sb.delete();
        m_push = 0; m_stall = 0; m_busy = 0; m_rr = 0; m_grant = 0;
        m_cnt = 0; m_cnt4 = 0; m_last = '0;
    end

    always @(negedge clk) begin
        logic [N-1:0] exp_pop;
        if (rst_n) begin
            exp_pop = '0;
            if (pop_ok()) exp_pop[winner()] = 1'b1;
            check("pop", 32'(pop_a), 32'(exp_pop));
            check("pop_b", 32'(pop_b), 32'(exp_pop));
            check("push", 32'(push_a), 32'(m_push));
            check("push_b", 32'(push_b), 32'(m_push));
            if (m_push) begin
                if (sb.size() == 0) begin
                    check("scoreboard_underflow", 32'(sb.size()), 32'd1);
                end else begin
                    m_last = sb.pop_front();
                end
            end
            check("data_out", 32'(dout_a), 32'(m_last));
            check("data_out_b", 32'(dout_b), 32'(m_last));
            check("busy", 32'(busy_a), 32'(m_busy));
            check("grant_idx", 32'(gidx_a), 32'(m_grant));
            check("words_sent", 32'(ws_a), 32'(m_cnt));
            check("words_sent_sat", 32'(ws_b), 32'(m_cnt4));
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input int i, input int n);
        for (int k = 0; k < n; k++) q[i].push_back(W'($urandom));
        refresh();
    endtask

    function automatic bit pending();
        bit p = (sb.size() > 0) || m_push;
        for (int i = 0; i < N; i++) if (q[i].size() > 0) p = 1;
        return p;
    endfunction

    task automatic drain(input string nm);
        int c = 0;
        while (pending() && c < 300) begin
            tick();
            c++;
        end
        if (c >= 300) check({nm, "_drain_timeout"}, 32'(c), 32'd0);
        tick();
        tick();
    endtask

    initial begin
        refresh();
        repeat (2) @(posedge clk);
        #1;
        check("rst_push", 32'(push_a), 32'd0);
        check("rst_pop", 32'(pop_a), 32'd0);
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_data", 32'(dout_a), 32'd0);
        check("rst_grant", 32'(gidx_a), 32'd0);
        check("rst_words", 32'(ws_a), 32'd0);
        tick();
        rst_n = 1'b1;

        // All inputs with three words each.
        for (int i = 0; i < N; i++) load(i, 3);
        enable = 1'b1;
        drain("t1");
        check("t1_words", 32'(ws_a), 32'd12);

        // Single non-empty input.
        load(2, 5);
        drain("t2");
        check("t2_grant", 32'(gidx_a), 32'd2);
        check("t2_words", 32'(ws_a), 32'd17);

        // Backpressure after two pops.
        for (int i = 0; i < N; i++) load(i, 4);
        tick();
        tick();
        afull = 1'b1;
        repeat (4) tick();
        afull = 1'b0;
        drain("t3");

        // Init while ACTIVE with pointer at 3.
        for (int i = 0; i < N; i++) load(i, 6);
        begin
            int c = 0;
            while (m_rr != 3 && c < 20) begin
                tick();
                c++;
            end
            check("t4_reach_ptr3", 32'(m_rr), 32'd3);
        end
        init = 1'b1;
        tick();
        init = 1'b0;
        check("t4_words_cleared", 32'(ws_a), 32'd0);
        drain("t4");

        // Asynchronous reset mid-burst.
        for (int i = 0; i < N; i++) load(i, 5);
        tick();
        tick();
        #1 rst_n = 1'b0;
        #1;
        check("t5_push", 32'(push_a), 32'd0);
        check("t5_pop", 32'(pop_a), 32'd0);
        check("t5_busy", 32'(busy_a), 32'd0);
        check("t5_words", 32'(ws_a), 32'd0);
        tick();
        rst_n = 1'b1;
        drain("t5");

        // Randomised traffic.
        for (int n = 0; n < 400; n++) begin
            tick();
            enable = ($urandom % 8) != 0;
            afull  = ($urandom % 4) == 0;
            init   = ($urandom % 32) == 0;
            if (($urandom % 3) == 0) load(int'($urandom % N), int'($urandom_range(1, 3)));
        end
        tick();
        enable = 1'b1;
        afull = 1'b0;
        init = 1'b0;
        drain("t6");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
